biriscv_mul_issue_ctrl: RTL and testbench

//  Upstream control stage for the iterative 16x16-based multiplier. Accepts MUL ops from issue with a

---
 rtl/biriscv_mul_issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_biriscv_mul_issue_ctrl.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_mul_issue_ctrl.sv
// Issue-side control for the iterative multiplier: handshake, dispatch, result return, flush and watchdog.
// Optional MUL_FASTPATH_EN resolves trivial products (operand 0 or 1) without dispatching.
module biriscv_mul_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        opcode_valid_i,
    output logic        opcode_accept_o,
    input  logic [4:0]  opcode_rd_idx_i,
    input  logic [31:0] opcode_ra_operand_i,
    input  logic [31:0] opcode_rb_operand_i,
    input  logic        flush_i,
    output logic        mul_valid_o,
    output logic [31:0] mul_ra_o,
    output logic [31:0] mul_rb_o,
    input  logic        mul_wb_valid_i,
    input  logic [31:0] mul_wb_value_i,
    output logic        busy_o,
    output logic [4:0]  busy_rd_o,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_idx_o,
    output logic [31:0] wb_value_o,
    output logic        timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISPATCH,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q;
    logic [31:0]       ra_q;
    logic [31:0]       rb_q;
    logic [4:0]        rd_q;
    logic [31:0]       value_q;
    logic [CNT_W-1:0]  cnt_q;

`ifdef MUL_FASTPATH_EN
    function automatic logic fast_hit(input logic [31:0] a, input logic [31:0] b);
        return (a == 32'd0) || (b == 32'd0) || (a == 32'd1) || (b == 32'd1);
    endfunction

    function automatic logic [31:0] fast_value(input logic [31:0] a, input logic [31:0] b);
        if ((a == 32'd0) || (b == 32'd0))
            return 32'd0;
        else if (a == 32'd1)
            return b;
        else
            return a;
    endfunction
`endif

    logic waiting_w;
    logic expire_w;

    assign waiting_w = (state_q == S_WAIT) || (state_q == S_DRAIN);
    // A result arriving on the last watchdog cycle wins over the timeout.
    assign expire_w  = waiting_w && (cnt_q == CNT_LAST) && !mul_wb_valid_i;

    assign opcode_accept_o = (state_q == S_IDLE) && !flush_i && !rst_i;
    assign mul_valid_o     = (state_q == S_DISPATCH);
    assign mul_ra_o        = ra_q;
    assign mul_rb_o        = rb_q;
    assign busy_o          = (state_q != S_IDLE);
    assign busy_rd_o       = busy_o ? rd_q : 5'd0;
    assign wb_valid_o      = (state_q == S_RESP) && !flush_i;
    assign wb_rd_idx_o     = rd_q;
    assign wb_value_o      = value_q;
    assign timeout_o       = expire_w;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rd_q    <= '0;
            value_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (opcode_valid_i && !flush_i) begin
                        ra_q <= opcode_ra_operand_i;
                        rb_q <= opcode_rb_operand_i;
                        rd_q <= opcode_rd_idx_i;
`ifdef MUL_FASTPATH_EN
                        if (fast_hit(opcode_ra_operand_i, opcode_rb_operand_i)) begin
                            value_q <= fast_value(opcode_ra_operand_i, opcode_rb_operand_i);
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_DISPATCH;
                        end
`else
                        state_q <= S_DISPATCH;
`endif
                    end
                end
                S_DISPATCH: begin
                    // The request cannot be withdrawn, so a flush here must still wait it out.
                    cnt_q   <= '0;
                    state_q <= flush_i ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (mul_wb_valid_i) begin
                        if (flush_i) begin
                            state_q <= S_IDLE;
                        end else begin
                            value_q <= mul_wb_value_i;
                            state_q <= S_RESP;
                        end
                    end else if (expire_w) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        if (flush_i)
                            state_q <= S_DRAIN;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                S_DRAIN: begin
                    if (mul_wb_valid_i || expire_w)
                        state_q <= S_IDLE;
                    else
                        cnt_q <= cnt_q + 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_biriscv_mul_issue_ctrl.sv
// Scoreboard bench for biriscv_mul_issue_ctrl with a fixed-latency (N=6) multiplier model.
module tb_biriscv_mul_issue_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic        opcode_valid_i;
    logic        opcode_accept_o;
    logic [4:0]  opcode_rd_idx_i;
    logic [31:0] opcode_ra_operand_i;
    logic [31:0] opcode_rb_operand_i;
    logic        flush_i;
    logic        mul_valid_o;
    logic [31:0] mul_ra_o;
    logic [31:0] mul_rb_o;
    logic        mul_wb_valid_i;
    logic [31:0] mul_wb_value_i;
    logic        busy_o;
    logic [4:0]  busy_rd_o;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_idx_o;
    logic [31:0] wb_value_o;
    logic        timeout_o;

    biriscv_mul_issue_ctrl dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .opcode_valid_i      (opcode_valid_i),
        .opcode_accept_o     (opcode_accept_o),
        .opcode_rd_idx_i     (opcode_rd_idx_i),
        .opcode_ra_operand_i (opcode_ra_operand_i),
        .opcode_rb_operand_i (opcode_rb_operand_i),
        .flush_i             (flush_i),
        .mul_valid_o         (mul_valid_o),
        .mul_ra_o            (mul_ra_o),
        .mul_rb_o            (mul_rb_o),
        .mul_wb_valid_i      (mul_wb_valid_i),
        .mul_wb_value_i      (mul_wb_value_i),
        .busy_o              (busy_o),
        .busy_rd_o           (busy_rd_o),
        .wb_valid_o          (wb_valid_o),
        .wb_rd_idx_o         (wb_rd_idx_o),
        .wb_value_o          (wb_value_o),
        .timeout_o           (timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int          checks;
    int          errors;
    int          cyc;
    logic [36:0] sb[$];
    logic [36:0] exp_e;
    bit          acc_flag;
    int          acc_cyc;
    int          mulv_cnt;
    int          mulv_cyc;
    int          wb_cnt;
    int          wb_cyc;
    int          to_cnt;
    int          to_cyc;
    int          cd;
    bit          model_en;
    logic [31:0] ma;
    logic [31:0] mb;

    // One clock: observe the cycle just before its closing edge, then advance the multiplier model.
    task automatic tick();
        #1;
        if (opcode_valid_i && opcode_accept_o) begin
            acc_flag = 1'b1;
            acc_cyc  = cyc;
            sb.push_back({opcode_rd_idx_i, opcode_ra_operand_i * opcode_rb_operand_i});
        end
        if (mul_valid_o) begin
            mulv_cnt++;
            mulv_cyc = cyc;
            cd = 6;
            ma = mul_ra_o;
            mb = mul_rb_o;
        end
        if (timeout_o) begin
            to_cnt++;
            to_cyc = cyc;
        end
        if (wb_valid_o) begin
            wb_cnt++;
            wb_cyc = cyc;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got rd=%0d value=%h, required no writeback", wb_rd_idx_o, wb_value_o);
            end else begin
                exp_e = sb.pop_front();
                if ({wb_rd_idx_o, wb_value_o} !== exp_e) begin
                    errors++;
                    $display("FAIL wb_result: got rd=%0d value=%h, required rd=%0d value=%h",
                             wb_rd_idx_o, wb_value_o, exp_e[36:32], exp_e[31:0]);
                end
            end
        end
        @(posedge clk_i);
        cyc++;
        #1;
        mul_wb_valid_i = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0 && model_en) begin
                mul_wb_valid_i = 1'b1;
                mul_wb_value_i = ma * mb;
            end
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input bit keep, output int t, output bit ok);
        opcode_ra_operand_i = a;
        opcode_rb_operand_i = b;
        opcode_rd_idx_i     = rd;
        opcode_valid_i      = 1'b1;
        acc_flag            = 1'b0;
        for (int i = 0; i < 40 && !acc_flag; i++) tick();
        ok = acc_flag;
        t  = acc_cyc;
        if (!keep) opcode_valid_i = 1'b0;
    endtask

    task automatic wait_wb(input int budget, output bit ok);
        int start;
        start = wb_cnt;
        for (int i = 0; i < budget && wb_cnt == start; i++) tick();
        ok = (wb_cnt != start);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if ({opcode_accept_o, busy_o, mul_valid_o, wb_valid_o, timeout_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got acc/busy/mulv/wbv/to=%b, required 00000",
                     {opcode_accept_o, busy_o, mul_valid_o, wb_valid_o, timeout_o});
        end
        checks++;
        if ({busy_rd_o, wb_rd_idx_o, wb_value_o, mul_ra_o, mul_rb_o} !== '0) begin
            errors++;
            $display("FAIL reset_data: got busy_rd=%0d wb_rd=%0d wb_val=%h ra=%h rb=%h, required all 0",
                     busy_rd_o, wb_rd_idx_o, wb_value_o, mul_ra_o, mul_rb_o);
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if (opcode_accept_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_accept: got %b, required 1", opcode_accept_o);
        end
    endtask

    task automatic test_basic();
        int t;
        bit ok;
        issue(32'h0001_0003, 32'h0002_0005, 5'd5, 1'b0, t, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_accept: got no accept, required accept within 40 cycles");
        end
        #1;
        checks++;
        if ({busy_o, busy_rd_o} !== {1'b1, 5'd5}) begin
            errors++;
            $display("FAIL basic_busy: got busy=%b rd=%0d, required busy=1 rd=5", busy_o, busy_rd_o);
        end
        wait_wb(30, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_wb_timeout: got no wb_valid_o, required one");
        end
        checks++;
        if (mulv_cyc !== t + 1) begin
            errors++;
            $display("FAIL basic_mulv_latency: got T+%0d, required T+1", mulv_cyc - t);
        end
        checks++;
        if (wb_cyc !== t + 8) begin
            errors++;
            $display("FAIL basic_wb_latency: got T+%0d, required T+8", wb_cyc - t);
        end
        #1;
        checks++;
        if ({mul_ra_o, mul_rb_o, busy_o, busy_rd_o} !== {32'h0001_0003, 32'h0002_0005, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL basic_hold: got ra=%h rb=%h busy=%b busy_rd=%0d, required 00010003 00020005 0 0",
                     mul_ra_o, mul_rb_o, busy_o, busy_rd_o);
        end
    endtask

    task automatic test_trivial_ops();
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        int t;
        int mv0;
        bit ok;
        ta[0] = 32'h1234_5678; tb[0] = 32'h0000_0000;
        ta[1] = 32'h0000_0001; tb[1] = 32'hDEAD_BEEF;
        ta[2] = 32'hCAFE_F00D; tb[2] = 32'h0000_0001;
        for (int k = 0; k < 3; k++) begin
            mv0 = mulv_cnt;
            issue(ta[k], tb[k], 5'(k + 10), 1'b0, t, ok);
            wait_wb(30, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL trivial_wb_timeout[%0d]: got no wb_valid_o, required one", k);
            end
`ifdef MUL_FASTPATH_EN
            checks++;
            if ((wb_cyc !== t + 1) || (mulv_cnt !== mv0)) begin
                errors++;
                $display("FAIL trivial_fast[%0d]: got wb at T+%0d with %0d dispatches, required T+1 with 0",
                         k, wb_cyc - t, mulv_cnt - mv0);
            end
`else
            checks++;
            if ((wb_cyc !== t + 8) || (mulv_cnt !== mv0 + 1)) begin
                errors++;
                $display("FAIL trivial_slow[%0d]: got wb at T+%0d with %0d dispatches, required T+8 with 1",
                         k, wb_cyc - t, mulv_cnt - mv0);
            end
`endif
            tick();
        end
    endtask

    task automatic test_flush();
        int t;
        int w0;
        bit ok;
        bit exp_acc;
        // Flush in IDLE blocks the accept that cycle.
        opcode_ra_operand_i = 32'd7;
        opcode_rb_operand_i = 32'd9;
        opcode_rd_idx_i     = 5'd3;
        opcode_valid_i      = 1'b1;
        flush_i             = 1'b1;
        acc_flag            = 1'b0;
        #1;
        checks++;
        if (opcode_accept_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_accept: got %b, required 0", opcode_accept_o);
        end
        tick();
        opcode_valid_i = 1'b0;
        flush_i        = 1'b0;
        checks++;
        if ({acc_flag, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL flush_idle_taken: got accepted=%b busy=%b, required 0 0", acc_flag, busy_o);
        end
        // Flush in the second WAIT cycle: no writeback, accept returns after the discarded result.
        w0 = wb_cnt;
        issue(32'h0000_0100, 32'h0000_0200, 5'd7, 1'b0, t, ok);
        while (cyc <= t + 9) begin
            flush_i = (cyc == t + 3);
            #1;
            exp_acc = (cyc >= t + 8);
            checks++;
            if (opcode_accept_o !== exp_acc) begin
                errors++;
                $display("FAIL flush_wait_accept: at T+%0d got %b, required %b", cyc - t, opcode_accept_o, exp_acc);
            end
            tick();
        end
        flush_i = 1'b0;
        // Flush coinciding with the multiplier result: discarded, back to IDLE.
        issue(32'h0000_0300, 32'h0000_0400, 5'd8, 1'b0, t, ok);
        while (cyc <= t + 7) begin
            flush_i = (cyc == t + 7);
            tick();
        end
        flush_i = 1'b0;
        #1;
        checks++;
        if ({opcode_accept_o, busy_o} !== 2'b10) begin
            errors++;
            $display("FAIL flush_wb_same: got accept=%b busy=%b, required 1 0", opcode_accept_o, busy_o);
        end
        tick();
        tick();
        checks++;
        if (wb_cnt !== w0) begin
            errors++;
            $display("FAIL flush_no_wb: got %0d writebacks, required 0", wb_cnt - w0);
        end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        int w1;
        bit ok;
        issue(32'hFFFF_FFFF, 32'h0000_0003, 5'd12, 1'b1, t1, ok);
        opcode_ra_operand_i = 32'h0001_0001;
        opcode_rb_operand_i = 32'h0001_0001;
        opcode_rd_idx_i     = 5'd13;
        acc_flag            = 1'b0;
        for (int i = 0; i < 40 && !acc_flag; i++) tick();
        w1 = wb_cyc;
        t2 = acc_cyc;
        opcode_valid_i = 1'b0;
        checks++;
        if (!acc_flag || (t2 !== w1 + 1) || (t2 !== t1 + 9)) begin
            errors++;
            $display("FAIL b2b_second_accept: got T+%0d (first wb at T+%0d), required T+9 after wb at T+8",
                     t2 - t1, w1 - t1);
        end
        wait_wb(30, ok);
        checks++;
        if (!ok || (wb_cyc !== t2 + 8)) begin
            errors++;
            $display("FAIL b2b_second_wb: got T2+%0d, required T2+8", wb_cyc - t2);
        end
        tick();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL b2b_drain: got %0d results outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_timeout();
        int t;
        int w0;
        int to0;
        bit ok;
        model_en = 1'b0;
        w0  = wb_cnt;
        to0 = to_cnt;
        issue(32'h0000_0011, 32'h0000_0022, 5'd9, 1'b0, t, ok);
        for (int i = 0; i < 30 && to_cnt == to0; i++) tick();
        checks++;
        if ((to_cnt == to0) || (to_cyc !== t + 17)) begin
            errors++;
            $display("FAIL timeout_pulse: got count=%0d at T+%0d, required one pulse at T+17", to_cnt - to0, to_cyc - t);
        end
        #1;
        checks++;
        if ({opcode_accept_o, busy_o} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_idle: got accept=%b busy=%b, required 1 0", opcode_accept_o, busy_o);
        end
        model_en       = 1'b1;
        mul_wb_value_i = 32'h5555_AAAA;
        mul_wb_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ((wb_cnt !== w0) || (to_cnt !== to0 + 1) || (busy_o !== 1'b0)) begin
            errors++;
            $display("FAIL timeout_late_wb: got wb=%0d timeouts=%0d busy=%b, required 0 1 0",
                     wb_cnt - w0, to_cnt - to0, busy_o);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid();
        int t;
        int w0;
        bit ok;
        w0 = wb_cnt;
        issue(32'h0000_0005, 32'h0000_0006, 5'd21, 1'b0, t, ok);
        for (int i = 0; i < 3; i++) tick();
        rst_i = 1'b1;
        #1;
        checks++;
        if ({busy_o, wb_valid_o, mul_valid_o, busy_rd_o} !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got busy=%b wbv=%b mulv=%b busy_rd=%0d, required all 0",
                     busy_o, wb_valid_o, mul_valid_o, busy_rd_o);
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if (opcode_accept_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_accept: got %b, required 1", opcode_accept_o);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if ((wb_cnt !== w0) || (busy_o !== 1'b0)) begin
            errors++;
            $display("FAIL reset_mid_late_wb: got wb=%0d busy=%b, required 0 0", wb_cnt - w0, busy_o);
        end
        sb.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        acc_flag = 1'b0;
        acc_cyc = 0;
        mulv_cnt = 0;
        mulv_cyc = 0;
        wb_cnt = 0;
        wb_cyc = 0;
        to_cnt = 0;
        to_cyc = 0;
        cd = 0;
        model_en = 1'b1;
        ma = '0;
        mb = '0;
        rst_i = 1'b1;
        opcode_valid_i = 1'b0;
        opcode_rd_idx_i = '0;
        opcode_ra_operand_i = '0;
        opcode_rb_operand_i = '0;
        flush_i = 1'b0;
        mul_wb_valid_i = 1'b0;
        mul_wb_value_i = '0;

        test_reset();
        test_basic();
        test_trivial_ops();
        test_flush();
        test_back_to_back();
        test_timeout();
        test_reset_mid();

        checks++;
        if (to_cnt !== 1) begin
            errors++;
            $display("FAIL timeout_total: got %0d pulses, required 1", to_cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
